mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Two-port arbiter sharing the single 256-bit line Data_Memory port between the data cache (M0)
//  and the instruction cache (M1). Latches the winning request, drives it to memory until ack,
//  and routes the one-cycle ack back to the winner only. Sits between CPU caches and Data_Memory.
// PARAMETERS
//  ADDR_W   32   byte-address width on all ports
//  LINE_W   256  cache-line / memory data width
// PORTS
//  clk_i          in   1       clock, all state updates on rising edge
//  rst_i          in   1       synchronous reset, active-low (0 = reset)
//  m0_enable_i    in   1       D-cache request; held high until m0_ack_o
//  m0_write_i     in   1       D-cache 1=write line, 0=read line
//  m0_addr_i      in   ADDR_W  D-cache line address
//  m0_data_i      in   LINE_W  D-cache write data
//  m0_ack_o       out  1       D-cache completion pulse
//  m1_enable_i / m1_write_i / m1_addr_i / m1_data_i / m1_ack_o   same as m0, for I-cache
//  rd_data_o      out  LINE_W  read data to both requesters (= mem_data_i)
//  mem_enable_o   out  1       to Data_Memory enable_i
//  mem_write_o    out  1       to Data_Memory write_i
//  mem_addr_o     out  ADDR_W  to Data_Memory addr_i
//  mem_data_o     out  LINE_W  to Data_Memory data_i
//  mem_ack_i      in   1       from Data_Memory ack_o (one-cycle pulse)
//  spurious_ack_o out  1       sticky: mem_ack_i seen in IDLE
// BEHAVIOUR
//  - FSM states: IDLE, BUSY0, BUSY1. Reset (rst_i=0 at edge) -> IDLE from any state; latched
//    addr/data/write cleared to 0; spurious_ack_o=0; round-robin pointer -> M0 (last-served=M1).
//  - All outputs reset to 0; mem_* driven only from registers (no comb. path from m*_ inputs).
//  - IDLE: if any enable high at edge, pick winner, latch its write/addr/data, -> BUSYx.
//    mem_enable_o = (state != IDLE); first memory cycle is the cycle after the request edge.
//  - BUSYx: mem_* held from latch; requester input changes ignored. m{x}_ack_o = mem_ack_i & BUSYx
//    (combinational). On edge with mem_ack_i=1 -> IDLE. Loser's ack always 0.
//  - Guaranteed >=1 IDLE cycle (mem_enable_o=0) between back-to-back transactions.
//  - Requester dropping enable while BUSYx: transaction still completes; ack pulse still issued.
//  - mem_ack_i while IDLE: ignored, spurious_ack_o set until reset.
//  - rd_data_o = mem_data_i always; valid only in the ack cycle of a read.
//  - Both requests same edge: winner per CONFIGURATION. Single request: granted immediately.
//  - Reset mid-transaction: pending ack discarded, no ack issued, requester must re-request.
// CONFIGURATION
//  MEM_ARB_RR_EN defined: simultaneous requests alternate; pointer toggles to the other port after
//   each completed transfer; single requester may win repeatedly.
//  MEM_ARB_RR_EN undefined: fixed priority, M0 (D-cache) always wins ties; M1 may starve.
// TESTING  (memory model: ack 10 cycles after enable rises, one-cycle pulse)
//  1 M0 read 0x00000020 alone -> mem_enable_o cycle after request, addr 0x20, write 0; m0_ack_o
//    with rd_data_o = model line; m1_ack_o stays 0; next cycle mem_enable_o=0.
//  2 M0 write 0x400 data 256'hA5 & M1 read 0x0 same edge -> M0 served first (both builds);
//    M1 granted after one IDLE cycle; model line 32 = 256'hA5.
//  3 Both held continuously, 4 transfers -> RR_EN: order M0,M1,M0,M1; no RR_EN: M0 x4, M1 none.
//  4 M1 drops enable 3 cycles into BUSY1 and changes addr -> mem_addr_o unchanged, m1_ack_o still
//    pulses once at cycle 10.
//  5 rst_i=0 for one edge at cycle 5 of BUSY0 -> state IDLE, mem_enable_o=0, later model ack
//    produces no m0_ack_o and sets spurious_ack_o=1.
//  6 Force mem_ack_i=1 in IDLE after reset -> spurious_ack_o=1, no m*_ack_o, stays 1 until reset.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one cache-line memory port between the D-cache (M0) and I-cache (M1).
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise M0 has fixed priority.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_enable_i,
  input  logic              m0_write_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [LINE_W-1:0] m0_data_i,
  output logic              m0_ack_o,
  input  logic              m1_enable_i,
  input  logic              m1_write_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [LINE_W-1:0] m1_data_i,
  output logic              m1_ack_o,
  output logic [LINE_W-1:0] rd_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic              spurious_ack_o,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              grant0;
  logic              grant1;
  logic              lat_write;
  logic [ADDR_W-1:0] lat_addr;
  logic [LINE_W-1:0] lat_data;
  logic              spurious;
`ifdef MEM_ARB_RR_EN
  logic              last_m1;
`endif

  // Handshake: a requester raises enable and holds it until its ack; ack is a single-cycle
  // pulse in the cycle memory acks. Enable/addr/data are sampled only at the grant edge.
  always_comb begin
    state_next = state;
    grant0     = 1'b0;
    grant1     = 1'b0;
    case (state)
      IDLE: begin
`ifdef MEM_ARB_RR_EN
        if (m0_enable_i && (!m1_enable_i || last_m1)) grant0 = 1'b1;
        else if (m1_enable_i)                        grant1 = 1'b1;
`else
        if (m0_enable_i)      grant0 = 1'b1;
        else if (m1_enable_i) grant1 = 1'b1;
`endif
        if (grant0)      state_next = BUSY0;
        else if (grant1) state_next = BUSY1;
      end
      BUSY0, BUSY1: begin
        if (mem_ack_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_data  <= '0;
      spurious  <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_m1   <= 1'b1;
`endif
    end else begin
      state <= state_next;
      if (grant0) begin
        lat_write <= m0_write_i;
        lat_addr  <= m0_addr_i;
        lat_data  <= m0_data_i;
      end else if (grant1) begin
        lat_write <= m1_write_i;
        lat_addr  <= m1_addr_i;
        lat_data  <= m1_data_i;
      end
      if (state == IDLE && mem_ack_i) spurious <= 1'b1;
`ifdef MEM_ARB_RR_EN
      // Pointer records who finished last so the other port wins the next tie.
      if (state == BUSY0 && mem_ack_i) last_m1 <= 1'b0;
      if (state == BUSY1 && mem_ack_i) last_m1 <= 1'b1;
`endif
    end
  end

  assign mem_enable_o   = (state != IDLE);
  assign mem_write_o    = lat_write;
  assign mem_addr_o     = lat_addr;
  assign mem_data_o     = lat_data;
  assign m0_ack_o       = mem_ack_i & (state == BUSY0);
  assign m1_ack_o       = mem_ack_i & (state == BUSY1);
  assign rd_data_o      = mem_data_i;
  assign spurious_ack_o = spurious;
  assign dbg_state      = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: memory model with fixed ack latency, scoreboard of
// expected transfers in service order, and directed plus random single-requester traffic.
module tb_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;
  localparam int LAT    = 10;
  localparam int EW     = 2 + ADDR_W + LINE_W;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic              m0_enable_i = 1'b0, m0_write_i = 1'b0;
  logic [ADDR_W-1:0] m0_addr_i = '0;
  logic [LINE_W-1:0] m0_data_i = '0;
  logic              m0_ack_o;
  logic              m1_enable_i = 1'b0, m1_write_i = 1'b0;
  logic [ADDR_W-1:0] m1_addr_i = '0;
  logic [LINE_W-1:0] m1_data_i = '0;
  logic              m1_ack_o;
  logic [LINE_W-1:0] rd_data_o;
  logic              mem_enable_o, mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_data_o;
  logic [LINE_W-1:0] mem_data_i = '0;
  logic              mem_ack_i;
  logic              spurious_ack_o;
  logic [1:0]        dbg_state;

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_enable_i(m0_enable_i), .m0_write_i(m0_write_i), .m0_addr_i(m0_addr_i),
    .m0_data_i(m0_data_i), .m0_ack_o(m0_ack_o),
    .m1_enable_i(m1_enable_i), .m1_write_i(m1_write_i), .m1_addr_i(m1_addr_i),
    .m1_data_i(m1_data_i), .m1_ack_o(m1_ack_o),
    .rd_data_o(rd_data_o), .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
    .mem_ack_i(mem_ack_i), .spurious_ack_o(spurious_ack_o), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;
  logic [EW-1:0]     exp_q[$];
  logic [LINE_W-1:0] model_mem[int];
  logic [LINE_W-1:0] ref_mem[int];

  task automatic check(input string tag, input logic [299:0] got, input logic [299:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] line_init(input int idx);
    logic [31:0] v;
    v = (32'(idx) * 32'h9E3779B1) ^ 32'h0BADF00D;
    return {8{v}};
  endfunction

  function automatic logic [LINE_W-1:0] model_rd(input int idx);
    if (model_mem.exists(idx)) return model_mem[idx];
    return line_init(idx);
  endfunction

  function automatic logic [LINE_W-1:0] ref_rd(input int idx);
    if (ref_mem.exists(idx)) return ref_mem[idx];
    return line_init(idx);
  endfunction

  // memory model: once enable is seen it commits to an ack in the 10th enable cycle
  logic              model_ack = 1'b0;
  logic              force_ack = 1'b0;
  logic              mbusy = 1'b0;
  int                mcnt = 0;
  logic              mwrite = 1'b0;
  logic [ADDR_W-1:0] maddr = '0;
  logic [LINE_W-1:0] mdata = '0;
  assign mem_ack_i = model_ack | force_ack;

  always @(posedge clk_i) begin
    if (model_ack) begin
      model_ack <= 1'b0;
      mbusy     <= 1'b0;
      if (mwrite) model_mem[int'(maddr[ADDR_W-1:5])] = mdata;
    end else if (mbusy) begin
      mcnt <= mcnt + 1;
      if (mcnt + 1 == LAT - 1) begin
        model_ack  <= 1'b1;
        mem_data_i <= mwrite ? '0 : model_rd(int'(maddr[ADDR_W-1:5]));
      end
    end else if (mem_enable_o) begin
      mbusy  <= 1'b1;
      mcnt   <= 1;
      mwrite <= mem_write_o;
      maddr  <= mem_addr_o;
      mdata  <= mem_data_o;
    end
  end

  // scoreboard monitor
  logic prev_ack = 1'b0;
  always @(negedge clk_i) begin
    logic [EW-1:0] e;
    if (prev_ack) check("idle_gap", mem_enable_o, 0);
    prev_ack = m0_ack_o | m1_ack_o;
    if (m0_ack_o && m1_ack_o) begin
      check("ack_both", {m0_ack_o, m1_ack_o}, 2'b01);
    end else if (m0_ack_o || m1_ack_o) begin
      if (exp_q.size() == 0) begin
        check("ack_unexpected", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check("ack_port", m1_ack_o, e[EW-1]);
        check("ack_write", mem_write_o, e[EW-2]);
        check("ack_addr", mem_addr_o, e[LINE_W +: ADDR_W]);
        if (e[EW-2]) check("wr_data", mem_data_o, e[LINE_W-1:0]);
        else         check("rd_data", rd_data_o, e[LINE_W-1:0]);
      end
    end
  end

  // driver tasks
  task automatic push_exp(input logic port, input logic write, input logic [ADDR_W-1:0] addr,
                          input logic [LINE_W-1:0] data);
    int idx;
    idx = int'(addr[ADDR_W-1:5]);
    if (write) begin
      ref_mem[idx] = data;
      exp_q.push_back({port, 1'b1, addr, data});
    end else begin
      exp_q.push_back({port, 1'b0, addr, ref_rd(idx)});
    end
  endtask

  task automatic drive_req(input logic port, input logic write, input logic [ADDR_W-1:0] addr,
                           input logic [LINE_W-1:0] data);
    if (!port) begin
      m0_enable_i = 1'b1; m0_write_i = write; m0_addr_i = addr; m0_data_i = data;
    end else begin
      m1_enable_i = 1'b1; m1_write_i = write; m1_addr_i = addr; m1_data_i = data;
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  task automatic run_single(input logic port, input logic write, input logic [ADDR_W-1:0] addr,
                            input logic [LINE_W-1:0] data, input int drop_at);
    int   n;
    logic got;
    @(negedge clk_i);
    push_exp(port, write, addr, data);
    drive_req(port, write, addr, data);
    n = 0;
    got = 1'b0;
    while (n < 40 && !got) begin
      @(negedge clk_i);
      #1;
      n++;
      if (n == 1) check("en_first", mem_enable_o, 1);
      if (drop_at != 0 && n == drop_at) begin
        if (!port) begin m0_enable_i = 1'b0; m0_addr_i = 32'hFFF0; end
        else       begin m1_enable_i = 1'b0; m1_addr_i = 32'hFFF0; end
      end
      if (port ? m1_ack_o : m0_ack_o) got = 1'b1;
    end
    check("ack_lat", n, LAT);
    m0_enable_i = 1'b0;
    m1_enable_i = 1'b0;
    repeat (2) @(negedge clk_i);
  endtask

  initial begin
    int n, k;
    logic done0, done1;
    logic [ADDR_W-1:0] waddr;
    logic [LINE_W-1:0] wdata;

    repeat (3) @(negedge clk_i);
    check("rst_state", dbg_state, 0);
    check("rst_en", mem_enable_o, 0);
    check("rst_wr", mem_write_o, 0);
    check("rst_addr", mem_addr_o, 0);
    check("rst_data", mem_data_o, 0);
    check("rst_acks", {m0_ack_o, m1_ack_o}, 0);
    check("rst_spur", spurious_ack_o, 0);
    rst_i = 1'b1;

    // 1: lone M0 read
    run_single(1'b0, 1'b0, 32'h20, '0, 0);

    // 2: simultaneous M0 write / M1 read from a fresh pointer
    do_reset();
    @(negedge clk_i);
    push_exp(1'b0, 1'b1, 32'h400, 256'hA5);
    push_exp(1'b1, 1'b0, 32'h0, '0);
    drive_req(1'b0, 1'b1, 32'h400, 256'hA5);
    drive_req(1'b1, 1'b0, 32'h0, '0);
    done0 = 1'b0; done1 = 1'b0;
    for (int c = 0; c < 60 && !(done0 && done1); c++) begin
      @(negedge clk_i);
      #1;
      if (m0_ack_o) begin m0_enable_i = 1'b0; done0 = 1'b1; end
      if (m1_ack_o) begin m1_enable_i = 1'b0; done1 = 1'b1; end
    end
    check("t2_done", {done0, done1}, 2'b11);
    m0_enable_i = 1'b0; m1_enable_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("mem_line32", model_rd(32), 256'hA5);

    // 3: both held for four transfers
    @(negedge clk_i);
`ifdef MEM_ARB_RR_EN
    push_exp(1'b0, 1'b0, 32'h100, '0);
    push_exp(1'b1, 1'b0, 32'h200, '0);
    push_exp(1'b0, 1'b0, 32'h100, '0);
    push_exp(1'b1, 1'b0, 32'h200, '0);
`else
    for (int i = 0; i < 4; i++) push_exp(1'b0, 1'b0, 32'h100, '0);
`endif
    drive_req(1'b0, 1'b0, 32'h100, '0);
    drive_req(1'b1, 1'b0, 32'h200, '0);
    k = 0;
    for (int c = 0; c < 100 && k < 4; c++) begin
      @(negedge clk_i);
      #1;
      if (m0_ack_o || m1_ack_o) k++;
    end
    m0_enable_i = 1'b0; m1_enable_i = 1'b0;
    check("t3_count", k, 4);
    repeat (2) @(negedge clk_i);

    // 4: M1 drops enable and changes addr mid-transfer
    run_single(1'b1, 1'b0, 32'h60, '0, 3);

    // 5: reset in cycle 5 of BUSY0
    @(negedge clk_i);
    drive_req(1'b0, 1'b0, 32'h80, '0);
    n = 0;
    while (n < 5) begin
      @(negedge clk_i);
      n++;
    end
    rst_i = 1'b0;
    m0_enable_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check("t5_state", dbg_state, 0);
    check("t5_en", mem_enable_o, 0);
    check("t5_spur0", spurious_ack_o, 0);
    repeat (10) @(negedge clk_i);
    check("t5_spur1", spurious_ack_o, 1);
    do_reset();
    #1;
    check("t5_spur_clr", spurious_ack_o, 0);

    // 6: forced ack while idle
    @(negedge clk_i);
    force_ack = 1'b1;
    @(negedge clk_i);
    force_ack = 1'b0;
    #1;
    check("t6_spur", spurious_ack_o, 1);
    repeat (5) @(negedge clk_i);
    check("t6_sticky", spurious_ack_o, 1);
    do_reset();
    #1;
    check("t6_clr", spurious_ack_o, 0);

    // random single-requester traffic, then read back the first write
    waddr = '0;
    for (int i = 0; i < 5; i++) begin
      logic [ADDR_W-1:0] a;
      logic              w;
      a = {21'd0, 6'($urandom_range(0, 63)), 5'd0};
      w = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      wdata = {8{$urandom}};
      if (i == 0) waddr = a;
      run_single(1'($urandom_range(0, 1)), w, a, wdata, 0);
    end
    run_single(1'b1, 1'b0, waddr, '0, 0);

    check("q_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
